// File: rtl/his_builder_fsm.sv
// his_builder_fsm: per-pixel timestamp histogram builder with peak search.
//
// Timestamps arrive round-robin over the pixels (pixel 0..N-1, then the next
// acquisition). Once a full frame has been collected, every pixel's histogram
// is scanned one bin per cycle. The bin with the highest count is then
// published on peakResult, and the counters are cleared for the next frame.
//
// Optional macro HIS_PEAK_CENTER_EN: when defined, report the centre of the
// peak bin. When undefined (default), report the bin's lower edge.
module his_builder_fsm #(
    parameter int NP                = 10,
    parameter int PIXEL_NUM_PER_RAM = 3,
    parameter int ACQ_NUM           = 2,
    parameter int HIST_BITS         = 4,
    parameter int CNT_W             = 8
) (
    input  logic          clk,
    input  logic          res,
    input  logic          wrEn,
    input  logic [NP-1:0] data,
    output logic [NP-1:0] peakResult [PIXEL_NUM_PER_RAM]
);

    localparam int BINS  = 1 << HIST_BITS;
    localparam int LOW_W = NP - HIST_BITS;
    localparam int PIX_W = (PIXEL_NUM_PER_RAM > 1) ? $clog2(PIXEL_NUM_PER_RAM) : 1;
    localparam int ACQ_W = (ACQ_NUM > 1) ? $clog2(ACQ_NUM) : 1;

    localparam logic [PIX_W-1:0] LAST_PIX = PIX_W'(PIXEL_NUM_PER_RAM - 1);
    localparam logic [ACQ_W-1:0] LAST_ACQ = ACQ_W'(ACQ_NUM - 1);

`ifdef HIS_PEAK_CENTER_EN
    // Half a bin width: moves the reported value from the lower edge to the centre.
    localparam logic [NP-1:0] PEAK_OFFSET = NP'(1) << (LOW_W - 1);
`else
    localparam logic [NP-1:0] PEAK_OFFSET = '0;
`endif

    typedef enum logic [1:0] {
        ACCUM,
        SEARCH,
        UPDATE
    } state_t;

    state_t state;
    state_t next_state;

    // Frame position of the next accepted sample.
    logic [PIX_W-1:0] pix_idx;
    logic [ACQ_W-1:0] acq_idx;

    // Bin currently being compared during SEARCH.
    logic [HIST_BITS-1:0] bin_idx;

    // Histogram storage and running peak trackers, one set per pixel.
    logic [CNT_W-1:0]     bin_cnt [PIXEL_NUM_PER_RAM][BINS];
    logic [CNT_W-1:0]     max_cnt [PIXEL_NUM_PER_RAM];
    logic [HIST_BITS-1:0] max_bin [PIXEL_NUM_PER_RAM];

    // Control strobes decoded from the state.
    logic accept;
    logic start_search;
    logic search_en;
    logic update_en;

    logic frame_done;
    logic search_last;

    logic [HIST_BITS-1:0] bin_sel;
    logic                 unused_data_low;

    // Only the top bits of the timestamp select a bin; the remaining bits are
    // resolution inside the bin and are not needed.
    assign bin_sel         = data[NP-1 -: HIST_BITS];
    assign unused_data_low = ^data[LOW_W-1:0];

    assign frame_done  = (pix_idx == LAST_PIX) && (acq_idx == LAST_ACQ);
    assign search_last = (bin_idx == '1);

    // State register.
    always_ff @(posedge clk) begin
        if (res) begin
            state <= ACCUM;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: a frame closes on the last sample, the scan lasts one
    // cycle per bin, and the publish step lasts a single cycle.
    always_comb begin
        next_state = state;
        case (state)
            ACCUM: begin
                if (wrEn && frame_done) begin
                    next_state = SEARCH;
                end
            end
            SEARCH: begin
                if (search_last) begin
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                next_state = ACCUM;
            end
            default: begin
                next_state = ACCUM;
            end
        endcase
    end

    // Output decode. Writes are only accepted in ACCUM, so samples that arrive
    // during the scan or the publish step are dropped.
    always_comb begin
        accept       = 1'b0;
        start_search = 1'b0;
        search_en    = 1'b0;
        update_en    = 1'b0;
        case (state)
            ACCUM: begin
                accept       = wrEn;
                start_search = wrEn && frame_done;
            end
            SEARCH: begin
                search_en = 1'b1;
            end
            UPDATE: begin
                update_en = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // Pixel and acquisition indices. Both wrap to zero on the last sample of a
    // frame, so the next frame starts at pixel 0 of acquisition 0.
    always_ff @(posedge clk) begin
        if (res) begin
            pix_idx <= '0;
            acq_idx <= '0;
        end else if (accept) begin
            if (pix_idx == LAST_PIX) begin
                pix_idx <= '0;
                if (acq_idx == LAST_ACQ) begin
                    acq_idx <= '0;
                end else begin
                    acq_idx <= acq_idx + 1'b1;
                end
            end else begin
                pix_idx <= pix_idx + 1'b1;
            end
        end
    end

    // Scan pointer. It wraps naturally to zero after the last bin.
    always_ff @(posedge clk) begin
        if (res) begin
            bin_idx <= '0;
        end else if (search_en) begin
            bin_idx <= bin_idx + 1'b1;
        end
    end

    // Bin counters: saturating increment of the addressed bin, and a full
    // clear when the result is published.
    always_ff @(posedge clk) begin
        if (res || update_en) begin
            for (int unsigned p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                for (int unsigned b = 0; b < BINS; b++) begin
                    bin_cnt[p][b] <= '0;
                end
            end
        end else if (accept && (bin_cnt[pix_idx][bin_sel] != '1)) begin
            bin_cnt[pix_idx][bin_sel] <= bin_cnt[pix_idx][bin_sel] + 1'b1;
        end
    end

    // Peak trackers. Bins are scanned in ascending order and replace the peak
    // only on a strictly greater count, so the lowest maximal bin wins a tie.
    always_ff @(posedge clk) begin
        if (res || start_search) begin
            for (int unsigned p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                max_cnt[p] <= '0;
                max_bin[p] <= '0;
            end
        end else if (search_en) begin
            for (int unsigned p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                if (bin_cnt[p][bin_idx] > max_cnt[p]) begin
                    max_cnt[p] <= bin_cnt[p][bin_idx];
                    max_bin[p] <= bin_idx;
                end
            end
        end
    end

    // Published result: the peak bin scaled back to timestamp units. It holds
    // until the next frame completes.
    always_ff @(posedge clk) begin
        if (res) begin
            for (int unsigned p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                peakResult[p] <= '0;
            end
        end else if (update_en) begin
            for (int unsigned p = 0; p < PIXEL_NUM_PER_RAM; p++) begin
                peakResult[p] <= (NP'(max_bin[p]) << LOW_W) | PEAK_OFFSET;
            end
        end
    end

endmodule

// File: tb/tb_his_builder_fsm.sv
// Testbench for his_builder_fsm.
// The bench applies a table of directed vectors, a few hand-written corner
// sequences, and randomized traffic. Every cycle is compared against a
// frame-level reference model.
module tb_his_builder_fsm;

    localparam int NP    = 10;
    localparam int P     = 3;
    localparam int A     = 2;
    localparam int HB    = 4;
    localparam int CW    = 8;
    localparam int NBIN  = 1 << HB;
    localparam int BIN_W = 1 << (NP - HB);
`ifdef HIS_PEAK_CENTER_EN
    localparam int HALF  = BIN_W / 2;
`else
    localparam int HALF  = 0;
`endif
    localparam int R0 = 1 * BIN_W + HALF;
    localparam int R1 = 0 * BIN_W + HALF;
    localparam int R2 = 15 * BIN_W + HALF;

    logic          clk = 1'b0;
    logic          res;
    logic          wrEn;
    logic [NP-1:0] data;
    logic [NP-1:0] peak [P];

    always #5 clk = ~clk;

    his_builder_fsm #(
        .NP(NP),
        .PIXEL_NUM_PER_RAM(P),
        .ACQ_NUM(A),
        .HIST_BITS(HB),
        .CNT_W(CW)
    ) dut (
        .clk(clk),
        .res(res),
        .wrEn(wrEn),
        .data(data),
        .peakResult(peak)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model: it collects a frame of samples, builds the histograms
    // arithmetically, and publishes the result a fixed number of edges later.
    int samp[$];
    int busy = 0;
    int pend [P];
    int mexp [P];

    task automatic model_edge(input bit r, input bit w, input int d);
        if (r) begin
            samp.delete();
            busy = 0;
            for (int p = 0; p < P; p++) mexp[p] = 0;
        end else if (busy > 0) begin
            busy--;
            if (busy == 0) begin
                for (int p = 0; p < P; p++) mexp[p] = pend[p];
            end
        end else if (w) begin
            samp.push_back(d);
            if (samp.size() == P * A) begin
                for (int p = 0; p < P; p++) begin
                    int hist [NBIN];
                    int best;
                    for (int b = 0; b < NBIN; b++) hist[b] = 0;
                    for (int k = p; k < P * A; k += P) begin
                        if (hist[samp[k] / BIN_W] < (1 << CW) - 1) hist[samp[k] / BIN_W]++;
                    end
                    best = 0;
                    for (int b = 1; b < NBIN; b++) begin
                        if (hist[b] > hist[best]) best = b;
                    end
                    pend[p] = best * BIN_W + HALF;
                end
                samp.delete();
                busy = NBIN + 1;
            end
        end
    endtask

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // This task is entered on a falling edge. It drives the inputs, lets one
    // rising edge pass, and checks against the model on the next falling edge.
    task automatic cycle(input bit r, input bit w, input int d);
        res  = r;
        wrEn = w;
        data = NP'(d);
        @(posedge clk);
        model_edge(r, w, d);
        @(negedge clk);
        for (int p = 0; p < P; p++) check($sformatf("model_pix%0d", p), int'(peak[p]), mexp[p]);
    endtask

    task automatic expect3(input string name, input int e0, input int e1, input int e2);
        check({name, "_p0"}, int'(peak[0]), e0);
        check({name, "_p1"}, int'(peak[1]), e1);
        check({name, "_p2"}, int'(peak[2]), e2);
    endtask

    task automatic frame(input int s0, s1, s2, s3, s4, s5);
        cycle(1'b0, 1'b1, s0); cycle(1'b0, 1'b1, s1); cycle(1'b0, 1'b1, s2);
        cycle(1'b0, 1'b1, s3); cycle(1'b0, 1'b1, s4); cycle(1'b0, 1'b1, s5);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 0);
    endtask

    typedef struct {
        bit r;
        bit w;
        int d;
        bit chk;
        int e0;
        int e1;
        int e2;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input bit r, input bit w, input int d, input bit chk,
                       input int e0, input int e1, input int e2);
        vec_t v;
        v.r = r; v.w = w; v.d = d; v.chk = chk; v.e0 = e0; v.e1 = e1; v.e2 = e2;
        tbl.push_back(v);
    endtask

    int s25 [6] = '{108, 511, 1023, 100, 50, 1000};

    initial begin
        res  = 1'b1;
        wrEn = 1'b0;
        data = '0;

        // Directed table: the reference stream, first back-to-back and then
        // with idle gaps between samples.
        add(1'b1, 1'b1, 500, 1'b1, 0, 0, 0);
        for (int i = 0; i < 6; i++) add(1'b0, 1'b1, s25[i], 1'b1, 0, 0, 0);
        for (int i = 0; i < NBIN; i++) add(1'b0, 1'b0, 0, 1'b1, 0, 0, 0);
        add(1'b0, 1'b0, 0, 1'b1, R0, R1, R2);
        add(1'b0, 1'b0, 0, 1'b1, R0, R1, R2);
        add(1'b1, 1'b0, 0, 1'b1, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            for (int g = 0; g < i % 3; g++) add(1'b0, 1'b0, 0, 1'b1, 0, 0, 0);
            add(1'b0, 1'b1, s25[i], 1'b1, 0, 0, 0);
        end
        for (int i = 0; i < NBIN; i++) add(1'b0, 1'b0, 0, 1'b1, 0, 0, 0);
        add(1'b0, 1'b0, 0, 1'b1, R0, R1, R2);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            cycle(tbl[i].r, tbl[i].w, tbl[i].d);
            if (tbl[i].chk) expect3($sformatf("tbl%0d", i), tbl[i].e0, tbl[i].e1, tbl[i].e2);
        end

        // Samples offered during SEARCH are dropped, and the next frame is
        // built cleanly.
        cycle(1'b1, 1'b0, 0);
        frame(108, 511, 1023, 100, 50, 1000);
        for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 700);
        idle(NBIN + 1 - 5);
        expect3("first_frame", R0, R1, R2);
        frame(300, 500, 50, 1000, 48, 90);
        idle(NBIN);
        expect3("before_latency", R0, R1, R2);
        idle(1);
        expect3("search_drop", 4 * BIN_W + HALF, HALF, HALF);

        // A reset mid-frame discards partial samples, and reset overrides wrEn.
        cycle(1'b0, 1'b1, 100); cycle(1'b0, 1'b1, 200); cycle(1'b0, 1'b1, 300);
        cycle(1'b1, 1'b1, 400);
        expect3("reset_clear", 0, 0, 0);
        frame(0, 0, 0, 64, 64, 64);
        idle(NBIN + 1);
        expect3("reset_midframe", HALF, HALF, HALF);

        // A reset mid-SEARCH aborts the scan, so no result is published.
        cycle(1'b1, 1'b0, 0);
        frame(108, 511, 1023, 100, 50, 1000);
        idle(5);
        cycle(1'b1, 1'b0, 0);
        idle(NBIN + 4);
        expect3("reset_midsearch", 0, 0, 0);
        frame(108, 511, 1023, 100, 50, 1000);
        idle(NBIN + 1);
        expect3("after_abort", R0, R1, R2);

        // Randomized traffic is compared against the model on every cycle.
        for (int i = 0; i < 4000; i++) begin
            bit r;
            bit w;
            int d;
            r = ($urandom_range(0, 299) == 0);
            w = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 1) == 0) d = $urandom_range(0, (1 << NP) - 1);
            else d = $urandom_range(0, 3) * BIN_W + $urandom_range(0, BIN_W - 1);
            cycle(r, w, d);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/his_builder_fsm.md
HIS_BUILDER_FSM -- requirements
Module: hisBuilderFSM

Interface
REQ-001 Parameter NP, default 10: timestamp and result width in bits.
REQ-002 Parameter PIXEL_NUM_PER_RAM, default 3: number of pixels served by one instance.
REQ-003 Parameter ACQ_NUM, default 2: acquisitions per pixel per histogram frame.
REQ-004 Parameter HIST_BITS, default 4: histogram bin index width; bins = 2^HIST_BITS, bin width = 2^(NP-HIST_BITS).
REQ-005 Parameter CNT_W, default 8: per-bin counter width.
REQ-006 clk  input  1: single clock; all state changes on rising edge.
REQ-007 res  input  1: reset, synchronous, active-high.
REQ-008 wrEn  input  1: data-valid qualifier for data.
REQ-009 data  input  NP: raw TDC timestamp of one acquisition.
REQ-010 peakResult  output  array[PIXEL_NUM_PER_RAM] of NP: registered peak timestamp per pixel.

Function
REQ-011 The block SHALL hold, per pixel, 2^HIST_BITS bin counters of CNT_W bits; bin index = data[NP-1 -: HIST_BITS].
REQ-012 The FSM SHALL have states ACCUM, SEARCH, UPDATE.
REQ-013 In ACCUM, each edge with wrEn=1 SHALL accept data for the current pixel, increment its bin (saturating at 2^CNT_W-1) and advance pixel index 0,1,..,PIXEL_NUM_PER_RAM-1, wrapping to 0 and incrementing the acquisition index.
REQ-014 wrEn=0 in ACCUM SHALL leave counters, pixel and acquisition indices unchanged.
REQ-015 On the edge that accepts sample PIXEL_NUM_PER_RAM*ACQ_NUM (last pixel of last acquisition), the FSM SHALL enter SEARCH and clear both indices.
REQ-016 SEARCH SHALL last exactly 2^HIST_BITS cycles, comparing bin 0..2^HIST_BITS-1 in order for all pixels in parallel, tracking max count and its bin.
REQ-017 Tie rule: a bin replaces the current peak only if strictly greater, so the lowest-indexed maximal bin wins.
REQ-018 After the last bin, the FSM SHALL enter UPDATE for one cycle: register every peakResult, clear all bin counters, return to ACCUM.
REQ-019 Latency: peakResult changes on edge N+2^HIST_BITS+1 (17 at defaults) after the edge N accepting the final sample; otherwise peakResult holds.
REQ-020 wrEn=1 during SEARCH or UPDATE SHALL be ignored (sample dropped, no counter or index change).

Reset
REQ-021 res=1 at an edge SHALL force state ACCUM, all counters, indices, peak trackers and every peakResult to 0, overriding wrEn, including mid-frame or mid-SEARCH.
REQ-022 The first edge with res=0 and wrEn=1 SHALL be accepted as pixel 0 of acquisition 0.

Configuration
REQ-023 Macro HIS_PEAK_CENTER_EN defined: peakResult = {peak bin, 1'b1, zeros} (bin centre, bin*2^(NP-HIST_BITS) + 2^(NP-HIST_BITS-1)).
REQ-024 HIS_PEAK_CENTER_EN undefined: peakResult = {peak bin, zeros} (bin lower edge, bin*2^(NP-HIST_BITS)).

Verification (defaults, HIS_PEAK_CENTER_EN defined)
REQ-025 Reset then wrEn=1 stream 108,511,1023,100,50,1000 -> 17 cycles after last sample peakResult = {96, 32, 992} (pixel 1 tie bin7/bin0 resolves to bin0).
REQ-026 Same stream with wrEn=0 cycles inserted between samples -> identical result, shifted only by gap count.
REQ-027 Samples during SEARCH (e.g. 700 x 5) -> ignored; next frame 300,500,50,1000,48,90 -> peakResult = {288, 32, 32}.
REQ-028 Assert res=1 after 3 samples, then full frame 0,0,0,64,64,64 -> peakResult = {32,32,32}, no residue from pre-reset samples.
REQ-029 HIS_PEAK_CENTER_EN undefined, stream of REQ-025 -> peakResult = {64, 0, 960}.
